secp256k1_mult_mod_stream: RTL and testbench

- Fully pipelined 256-bit modular multiplier for the secp256k1 field prime p.
- Computes o_dat = (a*b) mod p.
- Datapath: Karatsuba-Ofman multiplier followed by the existing secp256k1_mod reduction.
- Generalised over the current multiplier wrapper:
  - parametrised Karatsuba depth;
  - user tag (ctl) passthrough;
  - credit-based backpressure, so i_rdy low never drops or corrupts in-flight results.
- Used by the point-arithmetic engine, which interleaves several independent operations tagged by ctl.

---
 rtl/secp256k1_pkg.sv | 10 +
 rtl/karatsuba_ofman_mult.sv | 39 +++
 rtl/mult_mod_stream_fifo.sv | 82 ++++++++
 rtl/mult_mod_stream_fifo_chk.sv | 12 +
 rtl/secp256k1_mod.sv | 50 +++++
 rtl/secp256k1_mult_mod_stream.sv | 142 ++++++++++++++
 tb/tb_secp256k1_mult_mod_stream.sv | 248 ++++++++++++++++++++++++
 7 files changed

// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field definitions: element type, prime, fold constant and
// reduction latency used to derive the streaming multiplier latency.
package secp256k1_pkg;
    typedef logic [255:0] fe_t;

    localparam fe_t P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    // 2^256 mod p = 2^32 + 977, used to fold the high half back into the low half
    localparam logic [32:0] P_FOLD = 33'h1_0000_03D1;
    localparam int MOD_LAT = 3;
endpackage

// File: rtl/karatsuba_ofman_mult.sv
// 256x256 Karatsuba-Ofman multiplier; the product leaves after LEVEL register
// stages so retiming can spread the partial products across the pipeline.
module karatsuba_ofman_mult
    import secp256k1_pkg::*;
#(
    parameter int LEVEL = 3
) (
    input  logic         i_clk,
    input  logic [255:0] i_dat_a,
    input  logic [255:0] i_dat_b,
    output logic [511:0] o_dat
);
    logic [255:0] ll_s;
    logic [255:0] hh_s;
    logic [257:0] mm_s;
    logic [257:0] mid_s;
    logic [511:0] prod_s;
    logic [511:0] pipe_r [LEVEL];

    // One Karatsuba split: three half-width products instead of four
    always_comb begin
        ll_s   = 256'(i_dat_a[127:0]) * 256'(i_dat_b[127:0]);
        hh_s   = 256'(i_dat_a[255:128]) * 256'(i_dat_b[255:128]);
        mm_s   = (258'(i_dat_a[255:128]) + 258'(i_dat_a[127:0])) *
                 (258'(i_dat_b[255:128]) + 258'(i_dat_b[127:0]));
        mid_s  = mm_s - 258'(ll_s) - 258'(hh_s);
        prod_s = {hh_s, ll_s} + (512'(mid_s) << 9'd128);
    end

    // Product delay line
    always_ff @(posedge i_clk) begin
        pipe_r[0] <= prod_s;
        for (int i = 1; i < LEVEL; i++) begin
            pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign o_dat = pipe_r[LEVEL-1];
endmodule

// File: rtl/mult_mod_stream_fifo.sv
// Synchronous output FIFO with registered head; any depth >= 2, pointers wrap
// modulo DEPTH. A write into an empty FIFO is visible on the next cycle.
module mult_mod_stream_fifo #(
    parameter int WIDTH = 265,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdat,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdat,
    output logic             o_val
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] head_s;
    logic             rd_s;
    logic             full_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Next occupancy and next head, bypassing the array when the new word is the head
    always_comb begin
        rd_s         = i_rd && o_val;
        full_s       = (cnt_r == CW'(DEPTH));
        rd_ptr_nxt_s = rd_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        cnt_nxt_s    = cnt_r + CW'(i_wr) - CW'(rd_s);
        if (i_wr && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_s = i_wdat;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            mem_r[wr_ptr_r] <= i_wdat;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            o_val    <= 1'b0;
            o_rdat   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= i_wr ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= rd_ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
            o_val    <= (cnt_nxt_s != {CW{1'b0}});
            if (cnt_nxt_s != {CW{1'b0}}) begin
                o_rdat <= head_s;
            end
        end
    end

    mult_mod_stream_fifo_chk u_chk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_wr   (i_wr),
        .i_rd   (rd_s),
        .i_full (full_s)
    );
endmodule

// File: rtl/mult_mod_stream_fifo_chk.sv
// Overflow checker for the streaming multiplier output buffer.
module mult_mod_stream_fifo_chk (
    input logic i_clk,
    input logic i_rst,
    input logic i_wr,
    input logic i_rd,
    input logic i_full
);
    // A write into a full buffer is legal only when the head leaves in the same cycle
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_wr && i_full && !i_rd));
endmodule

// File: rtl/secp256k1_mod.sv
// Three-stage reduction of a 512-bit value modulo the secp256k1 prime:
// two folds by 2^256 mod p, then one conditional subtraction.
module secp256k1_mod
    import secp256k1_pkg::*;
#(
    parameter int USE_MULT = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [511:0] i_dat,
    input  logic         i_val,
    input  logic         i_err,
    input  logic         i_rdy,
    output logic [255:0] o_dat,
    output logic         o_val,
    output logic         o_err
);
    logic [511:0]         x_s;
    logic [289:0]         t1_r;
    logic [256:0]         t2_r;
    logic [MOD_LAT-1:0]   val_r;
    logic [MOD_LAT-1:0]   err_r;

    // Either reduce the given product or form it from two packed operands
    always_comb begin
        if (USE_MULT != 0) begin
            x_s = 512'(i_dat[511:256]) * 512'(i_dat[255:0]);
        end else begin
            x_s = i_dat;
        end
    end

    // Fold, fold, subtract; second fold is below 2^256 + 2^67 < 2p
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            val_r <= {MOD_LAT{1'b0}};
            err_r <= {MOD_LAT{1'b0}};
            o_dat <= 256'd0;
        end else if (i_rdy) begin
            val_r <= {val_r[MOD_LAT-2:0], i_val};
            err_r <= {err_r[MOD_LAT-2:0], i_err};
            t1_r  <= 290'(x_s[511:256]) * 290'(P_FOLD) + 290'(x_s[255:0]);
            t2_r  <= 257'(t1_r[289:256]) * 257'(P_FOLD) + 257'(t1_r[255:0]);
            o_dat <= (t2_r >= 257'(P)) ? fe_t'(t2_r - 257'(P)) : t2_r[255:0];
        end
    end

    assign o_val = val_r[MOD_LAT-1];
    assign o_err = err_r[MOD_LAT-1];
endmodule

// File: rtl/secp256k1_mult_mod_stream.sv
// Pipelined (a*b) mod p with tag passthrough and credit-based backpressure.
// Define MULT_MOD_STREAM_STATS_EN to add saturating op/stall/backpressure counters.
module secp256k1_mult_mod_stream
    import secp256k1_pkg::*;
#(
    parameter int KARATSUBA_LEVEL = 3,
    parameter int CTL_BITS        = 8,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [255:0]        i_dat_a,
    input  logic [255:0]        i_dat_b,
    input  logic [CTL_BITS-1:0] i_ctl,
    input  logic                i_val,
    input  logic                i_err,
    output logic                o_rdy,
    output logic [255:0]        o_dat,
    output logic [CTL_BITS-1:0] o_ctl,
    output logic                o_val,
    output logic                o_err,
    input  logic                i_rdy
`ifdef MULT_MOD_STREAM_STATS_EN
    ,
    output logic [31:0]         o_stat_ops,
    output logic [31:0]         o_stat_stall,
    output logic [31:0]         o_stat_bp
`endif
);
    localparam int LAT     = KARATSUBA_LEVEL + MOD_LAT + 1;
    localparam int CTL_DLY = LAT - 1;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int FW      = 256 + CTL_BITS + 1;

    logic                accept_s;
    logic                pop_s;
    logic [CW-1:0]       inflight_r;
    logic                val_sr_r [KARATSUBA_LEVEL];
    logic                err_sr_r [KARATSUBA_LEVEL];
    logic [CTL_BITS-1:0] ctl_sr_r [CTL_DLY];
    logic [511:0]        prod_s;
    logic [255:0]        mod_dat_s;
    logic                mod_val_s;
    logic                mod_err_s;
    logic [FW-1:0]       fifo_rdat_s;

    assign accept_s = i_val && o_rdy;
    assign pop_s    = o_val && i_rdy;
    // Every credit reserves a FIFO slot, so the pipelines below never stall
    assign o_rdy    = !i_rst && (inflight_r < CW'(FIFO_DEPTH));

    // Credit counter: ops accepted but not yet popped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_r <= {CW{1'b0}};
        end else if (accept_s && !pop_s) begin
            inflight_r <= inflight_r + CW'(1);
        end else if (!accept_s && pop_s) begin
            inflight_r <= inflight_r - CW'(1);
        end else begin
            inflight_r <= inflight_r;
        end
    end

    // Sideband alongside the multiplier; ctl runs on through the reduction too
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < KARATSUBA_LEVEL; i++) begin
                val_sr_r[i] <= 1'b0;
                err_sr_r[i] <= 1'b0;
            end
            for (int i = 0; i < CTL_DLY; i++) begin
                ctl_sr_r[i] <= {CTL_BITS{1'b0}};
            end
        end else begin
            val_sr_r[0] <= accept_s;
            err_sr_r[0] <= i_err;
            ctl_sr_r[0] <= i_ctl;
            for (int i = 1; i < KARATSUBA_LEVEL; i++) begin
                val_sr_r[i] <= val_sr_r[i-1];
                err_sr_r[i] <= err_sr_r[i-1];
            end
            for (int i = 1; i < CTL_DLY; i++) begin
                ctl_sr_r[i] <= ctl_sr_r[i-1];
            end
        end
    end

    karatsuba_ofman_mult #(.LEVEL(KARATSUBA_LEVEL)) u_mult (
        .i_clk   (i_clk),
        .i_dat_a (i_dat_a),
        .i_dat_b (i_dat_b),
        .o_dat   (prod_s)
    );

    secp256k1_mod #(.USE_MULT(0)) u_mod (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_dat (prod_s),
        .i_val (val_sr_r[KARATSUBA_LEVEL-1]),
        .i_err (err_sr_r[KARATSUBA_LEVEL-1]),
        .i_rdy (1'b1),
        .o_dat (mod_dat_s),
        .o_val (mod_val_s),
        .o_err (mod_err_s)
    );

    mult_mod_stream_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_wr   (mod_val_s),
        .i_wdat ({mod_err_s, ctl_sr_r[CTL_DLY-1], mod_dat_s}),
        .i_rd   (i_rdy),
        .o_rdat (fifo_rdat_s),
        .o_val  (o_val)
    );

    assign {o_err, o_ctl, o_dat} = fifo_rdat_s;

`ifdef MULT_MOD_STREAM_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    // Saturating activity counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stat_ops   <= 32'd0;
            o_stat_stall <= 32'd0;
            o_stat_bp    <= 32'd0;
        end else begin
            o_stat_ops   <= sat_inc(o_stat_ops, accept_s);
            o_stat_stall <= sat_inc(o_stat_stall, i_val && !o_rdy);
            o_stat_bp    <= sat_inc(o_stat_bp, o_val && !i_rdy);
        end
    end
`endif
endmodule

// File: tb/tb_secp256k1_mult_mod_stream.sv
// Scoreboard bench for secp256k1_mult_mod_stream: expected results come from
// plain (a*b) % p arithmetic and are checked in order by an output monitor.
module tb_secp256k1_mult_mod_stream;
    import secp256k1_pkg::*;

    localparam int K   = 3;
    localparam int CB  = 8;
    localparam int FD  = 8;
    localparam int LAT = K + 3 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [255:0]  i_dat_a = '0;
    logic [255:0]  i_dat_b = '0;
    logic [CB-1:0] i_ctl = '0;
    logic          i_val = 1'b0;
    logic          i_err = 1'b0;
    logic          i_rdy = 1'b1;
    logic          o_rdy;
    logic [255:0]  o_dat;
    logic [CB-1:0] o_ctl;
    logic          o_val;
    logic          o_err;
`ifdef MULT_MOD_STREAM_STATS_EN
    logic [31:0]   o_stat_ops;
    logic [31:0]   o_stat_stall;
    logic [31:0]   o_stat_bp;
`endif

    always #5 clk = ~clk;

    secp256k1_mult_mod_stream #(.KARATSUBA_LEVEL(K), .CTL_BITS(CB), .FIFO_DEPTH(FD)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_dat_a (i_dat_a),
        .i_dat_b (i_dat_b),
        .i_ctl   (i_ctl),
        .i_val   (i_val),
        .i_err   (i_err),
        .o_rdy   (o_rdy),
        .o_dat   (o_dat),
        .o_ctl   (o_ctl),
        .o_val   (o_val),
        .o_err   (o_err),
        .i_rdy   (i_rdy)
`ifdef MULT_MOD_STREAM_STATS_EN
        ,
        .o_stat_ops   (o_stat_ops),
        .o_stat_stall (o_stat_stall),
        .o_stat_bp    (o_stat_bp)
`endif
    );

    typedef struct {
        logic [255:0]  dat;
        logic [CB-1:0] ctl;
        logic          err;
        int            t;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pops = 0;
    bit   chk_lat = 1'b0;

    function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] pr;
        pr = 512'(a) * 512'(b);
        return 256'(pr % 512'(P));
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v >= P) v = v - P;
        return v;
    endfunction

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [255:0] a, input logic [255:0] b,
                         input logic [CB-1:0] c, input logic e);
        @(posedge clk);
        #1;
        i_val = v; i_dat_a = a; i_dat_b = b; i_ctl = c; i_err = e;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
        check(nm, 512'(sb_q.size()), 512'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Input monitor: every accepted op gets its expected result queued
    always @(negedge clk) begin
        if (!rst && i_val && o_rdy)
            sb_q.push_back('{dat: model(i_dat_a, i_dat_b), ctl: i_ctl, err: i_err, t: cyc});
    end

    // Output monitor: in-order compare on every pop, stability while stalled
    logic          held = 1'b0;
    logic [255:0]  h_dat;
    logic [CB-1:0] h_ctl;
    logic          h_err;
    exp_t          e;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held)
                check("stall_stable", 512'({o_val, o_err, o_ctl, o_dat}), 512'({1'b1, h_err, h_ctl, h_dat}));
            if (o_val && i_rdy) begin
                held = 1'b0;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual ctl=%0h required=no output", o_ctl);
                end else begin
                    e = sb_q.pop_front();
                    check("ctl", 512'(o_ctl), 512'(e.ctl));
                    check("err", 512'(o_err), 512'(e.err));
                    if (!e.err) check("dat", 512'(o_dat), 512'(e.dat));
                    if (chk_lat) check("latency", 512'(cyc - e.t), 512'(LAT));
                    pops++;
                end
            end else if (o_val) begin
                held = 1'b1;
                h_dat = o_dat; h_ctl = o_ctl; h_err = o_err;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int cnt;
        int p0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rdy_in_reset", 512'(o_rdy), 512'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outs", 512'({o_val, o_err, o_ctl, o_dat}), 512'd0);
        check("rdy_after_reset", 512'(o_rdy), 512'd1);

        // Directed ops, spaced so the latency is measured on an empty pipeline
        chk_lat = 1'b1;
        drive(1'b1, 256'd2, 256'd3, 8'h11, 1'b0);
        drive(1'b0, 256'd0, 256'd0, 8'h00, 1'b0);
        wait_drain("drain_2x3");
        drive(1'b1, P - 256'd1, P - 256'd1, 8'h22, 1'b0);
        drive(1'b0, 256'd0, 256'd0, 8'h00, 1'b0);
        wait_drain("drain_pm1sq");
        drive(1'b1, P - 256'd1, 256'd2, 8'h33, 1'b0);
        drive(1'b0, 256'd0, 256'd0, 8'h00, 1'b0);
        wait_drain("drain_pm1x2");
        chk_lat = 1'b0;

        // 100 back-to-back random ops, one flagged as errored
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, rand_fe(), rand_fe(), 8'($urandom), (i == 50));
            @(negedge clk);
            if (!o_rdy) cnt++;
        end
        drive(1'b0, 256'd0, 256'd0, 8'h00, 1'b0);
        check("b2b_rdy_drops", 512'(cnt), 512'd0);
        wait_drain("drain_b2b");
        repeat (3) @(posedge clk);

        // Backpressure: credits run out after exactly FD accepts
        i_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, rand_fe(), rand_fe(), 8'($urandom), 1'b0);
            @(negedge clk);
            if (o_rdy) acc++;
            else break;
        end
        check("accepts_before_full", 512'(acc), 512'(FD));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, rand_fe(), rand_fe(), 8'($urandom), 1'b0);
            @(negedge clk);
            if (o_rdy) cnt++;
        end
        check("rdy_while_stalled", 512'(cnt), 512'd0);
        p0 = pops;
        @(posedge clk);
        #1;
        i_val = 1'b0;
        i_rdy = 1'b1;
        repeat (FD) @(negedge clk);
        #1;
        check("resume_rate", 512'(pops - p0), 512'(FD));
        wait_drain("drain_stall");
        repeat (2) @(posedge clk);

        // Reset with ops in flight
        for (int i = 0; i < 4; i++) drive(1'b1, rand_fe(), rand_fe(), 8'($urandom), 1'b0);
        @(posedge clk);
        #1;
        i_val = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_val) cnt++;
        end
        check("val_after_reset", 512'(cnt), 512'd0);
        chk_lat = 1'b1;
        drive(1'b1, 256'd5, 256'd7, 8'h5A, 1'b0);
        drive(1'b0, 256'd0, 256'd0, 8'h00, 1'b0);
        wait_drain("drain_5x7");
        chk_lat = 1'b0;
`ifdef MULT_MOD_STREAM_STATS_EN
        @(negedge clk);
        check("stat_ops", 512'(o_stat_ops), 512'd1);
        check("stat_stall", 512'(o_stat_stall), 512'd0);
        check("stat_bp", 512'(o_stat_bp), 512'd0);
`endif
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
